gray_seq_ctrl: RTL and testbench

//   Run-length sequencer for an N-bit Gray-code counter.

---
 rtl/gray_seq_pkg.sv | 17 +
 rtl/gray_seq_core.sv | 67 ++++++
 rtl/gray_seq_ctrl.sv | 104 ++++++++++
 tb/tb_gray_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray-code run-length sequencer:
// FSM state encoding and the binary-to-Gray conversion helper.
package gray_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // Widest counter the helper supports; callers cast to their own width.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_core.sv
// Gray counter datapath: binary count, its registered Gray code and a
// one-cycle wrap pulse. clr forces the count to zero; en performs one advance.
// Optional feature macro: GRAY_SEQ_DOWN_EN (adds dir, 1 = count down).
module gray_seq_core
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
`ifdef GRAY_SEQ_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap_pulse
);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             down;

`ifdef GRAY_SEQ_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    // Next count: clear wins over advance; wrap flags the max<->0 crossing.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clr) begin
            bin_d = '0;
        end else if (en) begin
            if (down) begin
                bin_d  = bin_q - WIDTH'(1);
                wrap_d = (bin_q == '0);
            end else begin
                bin_d  = bin_q + WIDTH'(1);
                wrap_d = (bin_q == {WIDTH{1'b1}});
            end
        end
        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    // Count, Gray code and wrap pulse all register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin        = bin_q;
    assign gray       = gray_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Run-length sequencer: advances a Gray counter exactly run_len times,
// with stop/pause control, busy status and done/wrap pulses.
// Optional feature macro: GRAY_SEQ_DOWN_EN (adds dir input for down-counting).
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
`ifdef GRAY_SEQ_DOWN_EN
    input  logic             dir,
`endif
    input  logic [LEN_W-1:0] run_len,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             clr;
    logic             en;

    // FSM and run-length bookkeeping; stop beats pause beats advance.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        clr         = 1'b0;
        en          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr         = 1'b1;
                    remaining_d = run_len;
                    state_d     = (run_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    en          = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                // Leaving HOLD costs one edge; advancing resumes from RUN.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    gray_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (en),
`ifdef GRAY_SEQ_DOWN_EN
        .dir       (dir),
`endif
        .bin       (bin_out),
        .gray      (gray_out),
        .wrap_pulse(wrap)
    );

    assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl (WIDTH=2): arithmetic reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_gray_seq_ctrl;

    localparam int W   = 2;
    localparam int LW  = 8;
    localparam int MOD = 1 << W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          pause;
    logic          dir;
    logic [LW-1:0] run_len;
    logic [W-1:0]  gray_out;
    logic [W-1:0]  bin_out;
    logic          busy;
    logic          done;
    logic          wrap;

    gray_seq_ctrl #(
        .WIDTH(W),
        .LEN_W(LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
`ifdef GRAY_SEQ_DOWN_EN
        .dir     (dir),
`endif
        .run_len (run_len),
        .gray_out(gray_out),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int wrap_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a count, how many advances are left, and flags for
    // "a run is in progress", "held by pause", "finishing this cycle".
    bit m_on, m_held, m_fin, m_wrap, m_adv;
    int m_left, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_held = 0; m_fin = 0; m_wrap = 0; m_adv = 0;
            m_left = 0; m_cnt = 0;
        end else begin
            m_wrap = 0;
            m_adv  = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_on) begin
                if (start) begin
                    m_cnt  = 0;
                    m_left = int'(run_len);
                    if (m_left == 0) m_fin = 1;
                    else begin m_on = 1; m_held = 0; end
                end
            end else if (stop) begin
                m_on = 0; m_held = 0;
            end else if (m_held) begin
                if (!pause) m_held = 0;
            end else if (pause) begin
                m_held = 1;
            end else begin
                m_adv = 1;
`ifdef GRAY_SEQ_DOWN_EN
                if (dir) begin
                    if (m_cnt == 0) m_wrap = 1;
                    m_cnt = (m_cnt + MOD - 1) % MOD;
                end else begin
                    if (m_cnt == MOD - 1) m_wrap = 1;
                    m_cnt = (m_cnt + 1) % MOD;
                end
`else
                if (m_cnt == MOD - 1) m_wrap = 1;
                m_cnt = (m_cnt + 1) % MOD;
`endif
                m_left--;
                if (m_left == 0) begin m_on = 0; m_fin = 1; end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    logic [W-1:0] prev_gray;
    bit           prev_ok = 0;
    always @(negedge clk) begin
        chk("gray_out", int'(gray_out), m_cnt ^ (m_cnt >> 1));
        chk("bin_out",  int'(bin_out),  m_cnt);
        chk("busy",     int'(busy),     int'(m_on));
        chk("done",     int'(done),     int'(m_fin));
        chk("wrap",     int'(wrap),     int'(m_wrap));
        if (prev_ok && !rst && m_adv)
            chk("gray_one_bit", $countones(gray_out ^ prev_gray), 1);
        if (done) done_cnt++;
        if (wrap) wrap_cnt++;
        prev_gray = gray_out;
        prev_ok   = !rst;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            step();
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    int exp_up[5]  = '{1, 3, 2, 0, 1};
    int exp_dn[3]  = '{2, 3, 1};
    int d0, w0, n;

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; dir = 0; run_len = '0;
        #1;
        chk("rst_gray", int'(gray_out), 0);
        chk("rst_busy", int'(busy), 0);
        #2 rst = 0;
        step();

        // 1: run_len=5, one wrap, done after the 5th advance
        d0 = done_cnt; w0 = wrap_cnt;
        start = 1; run_len = 8'd5;
        step();
        start = 0;
        chk("t1_busy_start", int'(busy), 1);
        chk("t1_gray_start", int'(gray_out), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_gray_seq", int'(gray_out), exp_up[i]);
            if (i == 3) chk("t1_wrap", int'(wrap), 1);
        end
        chk("t1_done", int'(done), 1);
        chk("t1_busy_end", int'(busy), 0);
        step();
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_wrap_once", wrap_cnt - w0, 1);
        chk("t1_done_drop", int'(done), 0);

        // 2: run_len=4 with pause held across three edges after 2nd advance
        start = 1; run_len = 8'd4;
        step();
        start = 0;
        step(); step();
        pause = 1;
        repeat (3) begin
            step();
            chk("t2_hold_gray", int'(gray_out), 3);
            chk("t2_hold_busy", int'(busy), 1);
        end
        pause = 0;
        wait_done(10, n);
        chk("t2_done_delay", n, 3);
        chk("t2_final_gray", int'(gray_out), 0);
        step();

        // 3: run_len=6, stop after 2nd advance
        start = 1; run_len = 8'd6;
        step();
        start = 0;
        step(); step();
        stop = 1;
        step();
        stop = 0;
        d0 = done_cnt;
        chk("t3_busy", int'(busy), 0);
        chk("t3_gray", int'(gray_out), 3);
        repeat (6) step();
        chk("t3_no_done", done_cnt - d0, 0);
        chk("t3_gray_kept", int'(gray_out), 3);

        // 4: run_len=0 goes straight to done
        start = 1; run_len = 8'd0;
        step();
        start = 0;
        chk("t4_done", int'(done), 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_gray", int'(gray_out), 0);
        step();
        chk("t4_done_drop", int'(done), 0);

        // start while busy must not re-sample run_len
        start = 1; run_len = 8'd3;
        step();
        run_len = 8'd1;
        step();
        start = 0;
        wait_done(10, n);
        chk("busy_start_bin", int'(bin_out), 3);
        step();

        // run of 9 wraps twice and ends on 9 mod 4
        w0 = wrap_cnt;
        start = 1; run_len = 8'd9;
        step();
        start = 0;
        wait_done(20, n);
        chk("t9_bin", int'(bin_out), 1);
        chk("t9_gray", int'(gray_out), 1);
        step();
        chk("t9_wraps", wrap_cnt - w0, 2);

        // 5: asynchronous reset mid-run
        start = 1; run_len = 8'd6;
        step();
        start = 0;
        step(); step();
        d0 = done_cnt;
        #1 rst = 1;
        #1;
        chk("t5_rst_gray", int'(gray_out), 0);
        chk("t5_rst_bin", int'(bin_out), 0);
        chk("t5_rst_busy", int'(busy), 0);
        start = 1; run_len = 8'd2;
        step(); step();
        chk("t5_start_in_rst", int'(busy), 0);
        chk("t5_no_done", done_cnt - d0, 0);
        rst = 0;
        step();
        start = 0;
        chk("t5_busy_after", int'(busy), 1);
        wait_done(10, n);
        chk("t5_bin", int'(bin_out), 2);
        step();

`ifdef GRAY_SEQ_DOWN_EN
        // 6: count down from zero
        w0 = wrap_cnt;
        dir = 1; start = 1; run_len = 8'd3;
        step();
        start = 0;
        chk("t6_gray_start", int'(gray_out), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_gray_seq", int'(gray_out), exp_dn[i]);
            if (i == 0) chk("t6_wrap", int'(wrap), 1);
        end
        chk("t6_done", int'(done), 1);
        step();
        chk("t6_wraps", wrap_cnt - w0, 1);
        dir = 0;
`endif

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
